// File: rtl/spi_stream_tx.sv
// Frame FIFO fed from the audio clock domain and drained MSB-first over an SPI slave port.
// SPI pins are sampled with clk and run mode 0 (CPOL=0, CPHA=0) with continuous streaming.
module spi_stream_tx #(
    parameter int SAMPLE_W = 16,
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sck,
    input  logic                         cs_n,
    output logic                         sdo,
    input  logic                         audio_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   pcm_in,
    input  logic                         clr_flags,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         data_avail,
    output logic                         overflow,
    output logic                         underrun,
    output logic                         led
);

    localparam int FRAME_W = NUM_CH * SAMPLE_W;
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = $clog2(DEPTH + 1);
    localparam int CW      = $clog2(FRAME_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state, next_state;

    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic cs_v1, cs_v2, cs_primed;
    logic sck_fall, cs_fall, cs_rise;

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               full, empty, push, pop;
    logic               do_load, do_shift, underrun_set, overflow_set;
    logic [FRAME_W-1:0] load_word;
    logic [FRAME_W-2:0] shreg;
    logic [CW-1:0]      bit_cnt;

    // cs_primed keeps a cs_n held low across reset from looking like a new falling edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_s3    <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_s3     <= 1'b1;
            cs_v1     <= 1'b0;
            cs_v2     <= 1'b0;
            cs_primed <= 1'b0;
        end else begin
            sck_s1    <= sck;
            sck_s2    <= sck_s1;
            sck_s3    <= sck_s2;
            cs_s1     <= cs_n;
            cs_s2     <= cs_s1;
            cs_s3     <= cs_s2;
            cs_v1     <= 1'b1;
            cs_v2     <= cs_v1;
            cs_primed <= cs_primed | (cs_v2 & cs_s2);
        end
    end

    assign sck_fall = sck_s3 & ~sck_s2;
    assign cs_fall  = cs_primed & cs_s3 & ~cs_s2;
    assign cs_rise  = ~cs_s3 & cs_s2;

    assign full         = (fifo_level == LW'(DEPTH));
    assign empty        = (fifo_level == '0);
    assign push         = audio_valid & (~full | pop);
    assign overflow_set = audio_valid & ~push;
    assign load_word    = pop ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pcm_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            overflow <= overflow_set | (overflow & ~clr_flags);
            underrun <= underrun_set | (underrun & ~clr_flags);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (cs_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) next_state = LOAD;
                LOAD:    next_state = SHIFT;
                SHIFT:   if (sck_fall && bit_cnt == '0) next_state = cs_s2 ? IDLE : LOAD;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        pop          = 1'b0;
        do_load      = 1'b0;
        do_shift     = 1'b0;
        underrun_set = 1'b0;
        case (state)
            LOAD: begin
                do_load      = 1'b1;
                pop          = ~empty;
                underrun_set = empty;
            end
            SHIFT:   do_shift = sck_fall;
            default: ;
        endcase
    end

    // sdo is the top bit of the shift register; shreg holds the bits still to follow it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            sdo     <= 1'b0;
        end else begin
            if (do_load) begin
                shreg   <= load_word[FRAME_W-2:0];
                bit_cnt <= CW'(FRAME_W - 1);
            end else if (do_shift) begin
                shreg   <= {shreg[FRAME_W-3:0], 1'b0};
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (next_state == IDLE) sdo <= 1'b0;
            else if (do_load)       sdo <= load_word[FRAME_W-1];
            else if (do_shift)      sdo <= shreg[FRAME_W-2];
        end
    end

    assign data_avail = ~empty;
    assign led        = overflow;

endmodule

// File: tb/tb_spi_stream_tx.sv
// Directed bench for spi_stream_tx: acts as the MCU side of the SPI link (mode 0, sck = clk/16)
// and as the audio source, checking every result against hand-computed values.
module tb_spi_stream_tx;

    localparam int SAMPLE_W = 16;
    localparam int NUM_CH   = 2;
    localparam int DEPTH    = 8;
    localparam int FRAME_W  = NUM_CH * SAMPLE_W;
    localparam int LW       = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset_n;
    logic               sck;
    logic               cs_n;
    logic               sdo;
    logic               audio_valid;
    logic [FRAME_W-1:0] pcm_in;
    logic               clr_flags;
    logic [LW-1:0]      fifo_level;
    logic               data_avail;
    logic               overflow;
    logic               underrun;
    logic               led;

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] data;

    spi_stream_tx #(.SAMPLE_W(SAMPLE_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sck(sck),
        .cs_n(cs_n),
        .sdo(sdo),
        .audio_valid(audio_valid),
        .pcm_in(pcm_in),
        .clr_flags(clr_flags),
        .fifo_level(fifo_level),
        .data_avail(data_avail),
        .overflow(overflow),
        .underrun(underrun),
        .led(led)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_frame(input logic [FRAME_W-1:0] frame);
        @(negedge clk);
        audio_valid = 1'b1;
        pcm_in      = frame;
        @(negedge clk);
        audio_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs_n = 1'b0;
    endtask

    // Samples sdo at each sck rise; cs_n rises together with the final sck fall
    task automatic shift_bits(input int nbits, output logic [63:0] word);
        word = '0;
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b1;
            word = {word[62:0], sdo};
            repeat (8) @(negedge clk);
            if (i == nbits - 1) cs_n = 1'b1;
            sck = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic transfer(input int nbits, output logic [63:0] word);
        cs_begin();
        repeat (8) @(negedge clk);
        shift_bits(nbits, word);
    endtask

    initial begin
        reset_n     = 1'b0;
        sck         = 1'b0;
        cs_n        = 1'b1;
        audio_valid = 1'b0;
        pcm_in      = '0;
        clr_flags   = 1'b0;
        #1;
        check_output("rst_sdo",        64'(sdo),        64'h0);
        check_output("rst_level",      64'(fifo_level), 64'h0);
        check_output("rst_data_avail", 64'(data_avail), 64'h0);
        check_output("rst_overflow",   64'(overflow),   64'h0);
        check_output("rst_underrun",   64'(underrun),   64'h0);
        check_output("rst_led",        64'(led),        64'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] single frame");
        push_frame(32'hA5A5_1234);
        check_output("basic_level1", 64'(fifo_level), 64'h1);
        check_output("basic_avail1", 64'(data_avail), 64'h1);
        transfer(32, data);
        check_output("basic_bits",   data,            64'hA5A5_1234);
        check_output("basic_level0", 64'(fifo_level), 64'h0);
        check_output("basic_avail0", 64'(data_avail), 64'h0);
        check_output("basic_no_urun", 64'(underrun),  64'h0);

        $display("[TB] overflow");
        for (int i = 0; i < 8; i++) push_frame(32'h0F0F_0000 | 32'(i));
        check_output("ovf_level_full", 64'(fifo_level), 64'h8);
        check_output("ovf_not_yet",    64'(overflow),   64'h0);
        @(negedge clk);
        audio_valid = 1'b1;
        clr_flags   = 1'b1;
        pcm_in      = 32'hFFFF_FFFF;
        @(negedge clk);
        audio_valid = 1'b0;
        clr_flags   = 1'b0;
        check_output("ovf_level_kept", 64'(fifo_level), 64'h8);
        check_output("ovf_set_wins",   64'(overflow),   64'h1);
        check_output("ovf_led",        64'(led),        64'h1);
        for (int i = 0; i < 8; i++) begin
            transfer(32, data);
            check_output("ovf_drain", data, 64'(32'h0F0F_0000 | 32'(i)));
        end
        check_output("ovf_drained", 64'(fifo_level), 64'h0);

        $display("[TB] underrun");
        transfer(32, data);
        check_output("urun_zero_bits", data,          64'h0);
        check_output("urun_flag",      64'(underrun), 64'h1);
        check_output("urun_ovf_sticky", 64'(overflow), 64'h1);
        pulse_clr();
        check_output("clr_underrun", 64'(underrun), 64'h0);
        check_output("clr_overflow", 64'(overflow), 64'h0);
        check_output("clr_led",      64'(led),      64'h0);

        $display("[TB] push and pop while full");
        for (int i = 0; i < 8; i++) push_frame(32'h5500_0000 | 32'(i));
        cs_begin();
        repeat (3) @(negedge clk);
        audio_valid = 1'b1;
        pcm_in      = 32'h7777_7777;
        @(negedge clk);
        audio_valid = 1'b0;
        check_output("swap_level", 64'(fifo_level), 64'h8);
        check_output("swap_no_ovf", 64'(overflow),  64'h0);
        repeat (4) @(negedge clk);
        shift_bits(32, data);
        check_output("swap_first", data, 64'h5500_0000);
        for (int i = 1; i < 8; i++) begin
            transfer(32, data);
            check_output("swap_drain", data, 64'(32'h5500_0000 | 32'(i)));
        end
        transfer(32, data);
        check_output("swap_pushed_last", data,            64'h7777_7777);
        check_output("swap_level0",      64'(fifo_level), 64'h0);
        check_output("swap_no_urun",     64'(underrun),   64'h0);

        $display("[TB] continuous streaming");
        push_frame(32'h1357_9BDF);
        push_frame(32'h2468_ACE0);
        transfer(64, data);
        check_output("stream_bits",    data,            64'h1357_9BDF_2468_ACE0);
        check_output("stream_no_urun", 64'(underrun),   64'h0);
        check_output("stream_level0",  64'(fifo_level), 64'h0);

        $display("[TB] aborted frame");
        push_frame(32'hDEAD_BEEF);
        push_frame(32'hCAFE_F00D);
        transfer(10, data);
        check_output("abort_partial", data,            64'h37A);
        check_output("abort_level",   64'(fifo_level), 64'h1);
        transfer(32, data);
        check_output("abort_next",    data,            64'hCAFE_F00D);
        check_output("abort_no_urun", 64'(underrun),   64'h0);

        $display("[TB] reset mid-frame");
        transfer(10, data);
        check_output("short_urun", 64'(underrun), 64'h1);
        push_frame(32'hF000_0001);
        push_frame(32'hF000_0002);
        push_frame(32'hF000_0003);
        cs_begin();
        repeat (8) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        check_output("pre_rst_sdo",   64'(sdo),        64'h1);
        check_output("pre_rst_level", 64'(fifo_level), 64'h2);
        reset_n = 1'b0;
        #1;
        check_output("mid_rst_sdo",      64'(sdo),        64'h0);
        check_output("mid_rst_level",    64'(fifo_level), 64'h0);
        check_output("mid_rst_avail",    64'(data_avail), 64'h0);
        check_output("mid_rst_underrun", 64'(underrun),   64'h0);
        check_output("mid_rst_overflow", 64'(overflow),   64'h0);
        check_output("mid_rst_led",      64'(led),        64'h0);
        @(negedge clk);
        sck = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_output("post_rst_no_start", 64'(underrun), 64'h0);
        check_output("post_rst_sdo",      64'(sdo),      64'h0);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        push_frame(32'h1234_5678);
        transfer(32, data);
        check_output("post_rst_bits",  data,            64'h1234_5678);
        check_output("post_rst_level", 64'(fifo_level), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
